ext_mem_arbiter: RTL

Round-robin arbiter and invalidate sequencer that shares the L2 cache native port between `N_MASTERS` L1 back-end buses (instruction and data) inside the external-memory subsystem. It grants one master at a time and holds the grant until the L2 returns `ready`. It also sequences L2 force-invalidate requests so that an invalidate is issued only when the L2 is idle and its upstream write buffer has drained.

---
 rtl/ext_mem_arbiter_pkg.sv | 36 +++
 rtl/ext_mem_rr_picker.sv | 31 +++
 rtl/ext_mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/ext_mem_arbiter_pkg.sv
// Shared native-bus layout for the external-memory interconnect: widths, field offsets
// and the arbiter state encoding.
package ext_mem_arbiter_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StInvWait, StInv} arb_state_e;

  // Request fields MSB-first: valid, addr, wdata, wstrb. Response: rdata, ready.
  localparam int unsigned ReqWstrbLsb  = 0;
  localparam int unsigned RespReadyBit = 0;
  localparam int unsigned RespRdataLsb = 1;

  function automatic int unsigned req_width(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int unsigned resp_width(int unsigned data_w);
    return data_w + 1;
  endfunction

  function automatic int unsigned req_valid_bit(int unsigned addr_w, int unsigned data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  function automatic int unsigned req_addr_lsb(int unsigned data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int unsigned req_wdata_lsb(int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned rr_index(int unsigned last, int unsigned k, int unsigned n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/ext_mem_rr_picker.sv
// Combinational round-robin priority encoder: first valid requester after the last grant.
module ext_mem_rr_picker
  import ext_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic [N_MASTERS-1:0] i_valid,
  input  logic [IDX_W-1:0]     i_last_grant,
  output logic                 o_any,
  output logic [IDX_W-1:0]     o_grant
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_any   = |i_valid;
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      w_idx = IDX_W'(rr_index(32'(i_last_grant), k, N_MASTERS));
      if (!w_found && i_valid[w_idx]) begin
        w_found = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter onto the L2 native port plus L2 force-invalidate sequencer.
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned REQ_W    = req_width(ADDR_W, DATA_W),
  localparam int unsigned RESP_W   = resp_width(DATA_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  input  logic                          inv_req,
  input  logic                          wtb_empty_in,
  output logic                          force_inv_out,
  output logic                          inv_pending
);

  localparam int unsigned IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned VALID_BIT = req_valid_bit(ADDR_W, DATA_W);

  arb_state_e         r_state, w_state_next;
  logic [IDX_W-1:0]   r_grant, w_grant_next;
  logic [IDX_W-1:0]   r_last_grant, w_last_grant_next;
  logic               r_inv_pending, w_inv_pending_next;
  logic [N_MASTERS-1:0] w_valid;
  logic               w_pick_any;
  logic [IDX_W-1:0]   w_pick_idx;

  always_comb begin
    w_valid = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      w_valid[i] = m_req[i*REQ_W + VALID_BIT];
    end
  end

  ext_mem_rr_picker #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .i_valid      (w_valid),
    .i_last_grant (r_last_grant),
    .o_any        (w_pick_any),
    .o_grant      (w_pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_grant       <= '0;
      r_last_grant  <= IDX_W'(N_MASTERS - 1);
      r_inv_pending <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_last_grant  <= w_last_grant_next;
      r_inv_pending <= w_inv_pending_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    s_req             = '0;
    m_resp            = '0;
    force_inv_out     = 1'b0;
    // A new request in the INV cycle survives the clear, queuing a follow-up invalidate.
    w_inv_pending_next = inv_req | (r_inv_pending & (r_state != StInv));

    unique case (r_state)
      StIdle: begin
        if (r_inv_pending) begin
          w_state_next = StInvWait;
        end else if (w_pick_any) begin
          w_grant_next = w_pick_idx;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        s_req = m_req[32'(r_grant)*REQ_W +: REQ_W];
        m_resp[32'(r_grant)*RESP_W +: RESP_W] = s_resp;
        if (s_resp[RespReadyBit]) begin
          w_last_grant_next = r_grant;
          w_state_next      = StIdle;
        end
      end
      StInvWait: begin
        if (wtb_empty_in) begin
          w_state_next = StInv;
        end
      end
      StInv: begin
        force_inv_out = 1'b1;
        w_state_next  = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign inv_pending = r_inv_pending;

endmodule
